// File: rtl/ocp_ram_arb2_pkg.sv
// rtl/ocp_ram_arb2_pkg.sv - OCP constants, bus widths and owner-tag type for the RAM arbiter
package ocp_ram_arb2_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  localparam logic [2:0] OCP_CMD_IDLE = 3'd0;
  localparam logic [2:0] OCP_CMD_WR   = 3'd1;
  localparam logic [2:0] OCP_CMD_RD   = 3'd2;

  localparam logic [1:0] OCP_RESP_NULL = 2'd0;
  localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
  localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

  // One in-flight command tag: whether a response is owed, and to which master.
  typedef struct packed {
    logic vld;
    logic id;
  } owner_t;

  function automatic logic ocp_is_req(input logic [2:0] cmd);
    return cmd != OCP_CMD_IDLE;
  endfunction

endpackage

// File: rtl/ocp_owner_pipe.sv
// rtl/ocp_owner_pipe.sv - DEPTH-stage {vld,id} shift register tracking response ownership
module ocp_owner_pipe
  import ocp_ram_arb2_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic in_vld,
  input  logic in_id,
  output logic tail_vld,
  output logic tail_id
);

  owner_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= '{vld: in_vld, id: in_id};
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tail_vld = stage[DEPTH-1].vld;
  assign tail_id  = stage[DEPTH-1].id;

endmodule

// File: rtl/ocp_ram_arb2.sv
// rtl/ocp_ram_arb2.sv - two-master round-robin OCP arbiter in front of the on-chip RAM gasket
module ocp_ram_arb2
  import ocp_ram_arb2_pkg::*;
#(
  parameter int RESP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_M0Addr,
  input  logic [2:0]            i_M0Cmd,
  input  logic [DATA_WIDTH-1:0] i_M0Data,
  input  logic [BEN_WIDTH-1:0]  i_M0ByteEn,
  output logic                  o_M0CmdAcc,
  output logic [DATA_WIDTH-1:0] o_M0SData,
  output logic [1:0]            o_M0SResp,
  input  logic [ADDR_WIDTH-1:0] i_M1Addr,
  input  logic [2:0]            i_M1Cmd,
  input  logic [DATA_WIDTH-1:0] i_M1Data,
  input  logic [BEN_WIDTH-1:0]  i_M1ByteEn,
  output logic                  o_M1CmdAcc,
  output logic [DATA_WIDTH-1:0] o_M1SData,
  output logic [1:0]            o_M1SResp,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  localparam int PIPE_DEPTH = (RESP_LAT < 1) ? 1 : RESP_LAT;

  logic prio;
  logic req0;
  logic req1;
  logic any_req;
  logic gnt_id;
  logic accept;
  logic tail_vld;
  logic tail_id;

  // Grant is purely combinational; reset masks it so nothing reaches the slave.
  always_comb begin
    req0    = ocp_is_req(i_M0Cmd);
    req1    = ocp_is_req(i_M1Cmd);
    any_req = nrst && (req0 || req1);
    gnt_id  = (req0 && req1) ? prio : req1;
    accept  = any_req && i_SCmdAccept;
  end

  always_comb begin
    o_MAddr   = '0;
    o_MCmd    = OCP_CMD_IDLE;
    o_MData   = '0;
    o_MByteEn = '0;
    if (any_req) begin
      if (gnt_id) begin
        o_MAddr   = i_M1Addr;
        o_MCmd    = i_M1Cmd;
        o_MData   = i_M1Data;
        o_MByteEn = i_M1ByteEn;
      end else begin
        o_MAddr   = i_M0Addr;
        o_MCmd    = i_M0Cmd;
        o_MData   = i_M0Data;
        o_MByteEn = i_M0ByteEn;
      end
    end
  end

  assign o_M0CmdAcc = accept && !gnt_id;
  assign o_M1CmdAcc = accept && gnt_id;

  // Priority flips away from whoever was just served; a stalled slave leaves it alone.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~gnt_id;
    end
  end

  ocp_owner_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_owner_pipe (
    .clk      (clk),
    .nrst     (nrst),
    .in_vld   (accept),
    .in_id    (gnt_id),
    .tail_vld (tail_vld),
    .tail_id  (tail_id)
  );

  // Responses with no tracked owner are dropped rather than guessed at.
  always_comb begin
    o_M0SResp = OCP_RESP_NULL;
    o_M1SResp = OCP_RESP_NULL;
    if (nrst && tail_vld) begin
      if (tail_id) begin
        o_M1SResp = i_SResp;
      end else begin
        o_M0SResp = i_SResp;
      end
    end
  end

  assign o_M0SData = i_SData;
  assign o_M1SData = i_SData;

endmodule

// File: tb/tb_ocp_ram_arb2.sv
// tb/tb_ocp_ram_arb2.sv - directed bench for ocp_ram_arb2 with RESP_LAT=1 and RESP_LAT=2 builds
module tb_ocp_ram_arb2;
  import ocp_ram_arb2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  nrst;
  logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic [2:0]            m0_cmd, m1_cmd;
  logic [DATA_WIDTH-1:0] m0_data, m1_data;
  logic [BEN_WIDTH-1:0]  m0_ben, m1_ben;
  logic                  s_cmd_accept;
  logic [DATA_WIDTH-1:0] s_data;
  logic [1:0]            s_resp1, s_resp2;

  logic                  a_m0_acc, a_m1_acc, b_m0_acc, b_m1_acc;
  logic [DATA_WIDTH-1:0] a_m0_sdata, a_m1_sdata, b_m0_sdata, b_m1_sdata;
  logic [1:0]            a_m0_sresp, a_m1_sresp, b_m0_sresp, b_m1_sresp;
  logic [ADDR_WIDTH-1:0] a_maddr, b_maddr;
  logic [2:0]            a_mcmd, b_mcmd;
  logic [DATA_WIDTH-1:0] a_mdata, b_mdata;
  logic [BEN_WIDTH-1:0]  a_mben, b_mben;

  int checks = 0;
  int errors = 0;

  ocp_ram_arb2 #(.RESP_LAT(1)) u_dut1 (
    .clk(clk), .nrst(nrst),
    .i_M0Addr(m0_addr), .i_M0Cmd(m0_cmd), .i_M0Data(m0_data), .i_M0ByteEn(m0_ben),
    .o_M0CmdAcc(a_m0_acc), .o_M0SData(a_m0_sdata), .o_M0SResp(a_m0_sresp),
    .i_M1Addr(m1_addr), .i_M1Cmd(m1_cmd), .i_M1Data(m1_data), .i_M1ByteEn(m1_ben),
    .o_M1CmdAcc(a_m1_acc), .o_M1SData(a_m1_sdata), .o_M1SResp(a_m1_sresp),
    .o_MAddr(a_maddr), .o_MCmd(a_mcmd), .o_MData(a_mdata), .o_MByteEn(a_mben),
    .i_SCmdAccept(s_cmd_accept), .i_SData(s_data), .i_SResp(s_resp1)
  );

  ocp_ram_arb2 #(.RESP_LAT(2)) u_dut2 (
    .clk(clk), .nrst(nrst),
    .i_M0Addr(m0_addr), .i_M0Cmd(m0_cmd), .i_M0Data(m0_data), .i_M0ByteEn(m0_ben),
    .o_M0CmdAcc(b_m0_acc), .o_M0SData(b_m0_sdata), .o_M0SResp(b_m0_sresp),
    .i_M1Addr(m1_addr), .i_M1Cmd(m1_cmd), .i_M1Data(m1_data), .i_M1ByteEn(m1_ben),
    .o_M1CmdAcc(b_m1_acc), .o_M1SData(b_m1_sdata), .o_M1SResp(b_m1_sresp),
    .o_MAddr(b_maddr), .o_MCmd(b_mcmd), .o_MData(b_mdata), .o_MByteEn(b_mben),
    .i_SCmdAccept(s_cmd_accept), .i_SData(s_data), .i_SResp(s_resp2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_cmd       = OCP_CMD_IDLE;
    m1_cmd       = OCP_CMD_IDLE;
    m0_addr      = '0;
    m1_addr      = '0;
    m0_data      = '0;
    m1_data      = '0;
    m0_ben       = '0;
    m1_ben       = '0;
    s_resp1      = OCP_RESP_NULL;
    s_resp2      = OCP_RESP_NULL;
    s_data       = '0;
    s_cmd_accept = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    idle_all();
    m0_cmd = OCP_CMD_WR; m0_addr = 16'h0A0A; m0_data = 32'h1111_1111; m0_ben = 4'hF;
    m1_cmd = OCP_CMD_WR; m1_addr = 16'h0B0B; m1_data = 32'h2222_2222; m1_ben = 4'h3;
    s_resp1 = OCP_RESP_DVA;
    step();
    step();
    @(negedge clk);
    checks++; if (a_mcmd !== OCP_CMD_IDLE) begin errors++; $display("FAIL rst_mcmd got %h want %h", a_mcmd, OCP_CMD_IDLE); end
    checks++; if (a_maddr !== '0) begin errors++; $display("FAIL rst_maddr got %h want 0", a_maddr); end
    checks++; if (a_mdata !== '0 || a_mben !== '0) begin errors++; $display("FAIL rst_mdata_ben got %h/%h want 0/0", a_mdata, a_mben); end
    checks++; if (a_m0_acc !== 1'b0 || a_m1_acc !== 1'b0) begin errors++; $display("FAIL rst_acc got %b%b want 00", a_m1_acc, a_m0_acc); end
    checks++; if (a_m0_sresp !== OCP_RESP_NULL || a_m1_sresp !== OCP_RESP_NULL) begin errors++; $display("FAIL rst_sresp got %h/%h want 0/0", a_m0_sresp, a_m1_sresp); end
    step();
    nrst = 1'b1;
    s_resp1 = OCP_RESP_NULL;
    @(negedge clk);
    checks++; if (a_m0_acc !== 1'b1 || a_m1_acc !== 1'b0) begin errors++; $display("FAIL rst_first_grant got m1/m0 %b%b want 01", a_m1_acc, a_m0_acc); end
    checks++; if (a_mcmd !== OCP_CMD_WR || a_maddr !== 16'h0A0A) begin errors++; $display("FAIL rst_first_fields got %h@%h want %h@0a0a", a_mcmd, a_maddr, OCP_CMD_WR); end
    checks++; if (a_mdata !== 32'h1111_1111 || a_mben !== 4'hF) begin errors++; $display("FAIL rst_first_data got %h/%h want 11111111/f", a_mdata, a_mben); end
  endtask

  task automatic test_single();
    step();
    idle_all();
    m1_cmd = OCP_CMD_RD; m1_addr = 16'h0100;
    @(negedge clk);
    checks++; if (a_m1_acc !== 1'b1 || a_m0_acc !== 1'b0) begin errors++; $display("FAIL single_acc got m1/m0 %b%b want 10", a_m1_acc, a_m0_acc); end
    checks++; if (a_mcmd !== OCP_CMD_RD || a_maddr !== 16'h0100) begin errors++; $display("FAIL single_fields got %h@%h want %h@0100", a_mcmd, a_maddr, OCP_CMD_RD); end
    step();
    idle_all();
    s_resp1 = OCP_RESP_DVA; s_data = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (a_m1_sresp !== OCP_RESP_DVA) begin errors++; $display("FAIL single_m1_resp got %h want %h", a_m1_sresp, OCP_RESP_DVA); end
    checks++; if (a_m0_sresp !== OCP_RESP_NULL) begin errors++; $display("FAIL single_m0_resp got %h want %h", a_m0_sresp, OCP_RESP_NULL); end
    checks++; if (a_m1_sdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_sdata got %h want cafef00d", a_m1_sdata); end
  endtask

  task automatic test_contention();
    int n0 = 0, n1 = 0, r0 = 0, r1 = 0;
    logic eg;
    logic prev_g = 1'b0;
    logic [ADDR_WIDTH-1:0] ea;
    for (int c = 0; c < 9; c++) begin
      step();
      idle_all();
      if (n0 < 4) begin m0_cmd = OCP_CMD_RD; m0_addr = ADDR_WIDTH'(32'h10 + n0); end
      if (n1 < 4) begin m1_cmd = OCP_CMD_RD; m1_addr = ADDR_WIDTH'(32'h20 + n1); end
      if (c > 0) begin s_resp1 = OCP_RESP_DVA; s_data = DATA_WIDTH'(32'hD000_0000 + c); end
      eg = (c % 2) == 1;
      ea = eg ? ADDR_WIDTH'(32'h20 + n1) : ADDR_WIDTH'(32'h10 + n0);
      @(negedge clk);
      if (c < 8) begin
        checks++; if (a_m0_acc !== !eg || a_m1_acc !== eg) begin errors++; $display("FAIL cont_grant c=%0d got m1/m0 %b%b want m1=%b", c, a_m1_acc, a_m0_acc, eg); end
        checks++; if (a_maddr !== ea) begin errors++; $display("FAIL cont_addr c=%0d got %h want %h", c, a_maddr, ea); end
      end
      if (c > 0) begin
        checks++;
        if (a_m0_sresp !== (prev_g ? OCP_RESP_NULL : OCP_RESP_DVA) || a_m1_sresp !== (prev_g ? OCP_RESP_DVA : OCP_RESP_NULL)) begin
          errors++; $display("FAIL cont_route c=%0d got m0=%h m1=%h want owner m%0d", c, a_m0_sresp, a_m1_sresp, prev_g);
        end
        if (a_m0_sresp == OCP_RESP_DVA) r0++;
        if (a_m1_sresp == OCP_RESP_DVA) r1++;
      end
      if (c < 8) begin
        if (eg) n1++; else n0++;
        prev_g = eg;
      end
    end
    checks++; if (r0 != 4 || r1 != 4) begin errors++; $display("FAIL cont_dva_count got %0d/%0d want 4/4", r0, r1); end
  endtask

  task automatic test_stall();
    step();
    idle_all();
    m0_cmd = OCP_CMD_WR; m0_addr = 16'h0030;
    @(negedge clk);
    checks++; if (a_m0_acc !== 1'b1) begin errors++; $display("FAIL stall_pre_acc got %b want 1", a_m0_acc); end
    for (int s = 0; s < 3; s++) begin
      step();
      idle_all();
      s_cmd_accept = 1'b0;
      m0_cmd = OCP_CMD_RD; m0_addr = 16'h0031;
      m1_cmd = OCP_CMD_RD; m1_addr = 16'h0041;
      if (s == 1) s_resp1 = OCP_RESP_DVA;
      @(negedge clk);
      checks++; if (a_m0_acc !== 1'b0 || a_m1_acc !== 1'b0) begin errors++; $display("FAIL stall_acc s=%0d got %b%b want 00", s, a_m1_acc, a_m0_acc); end
      checks++; if (a_maddr !== 16'h0041) begin errors++; $display("FAIL stall_prio_addr s=%0d got %h want 0041", s, a_maddr); end
      if (s == 1) begin
        checks++; if (a_m0_sresp !== OCP_RESP_NULL || a_m1_sresp !== OCP_RESP_NULL) begin errors++; $display("FAIL stall_drop got %h/%h want 0/0", a_m0_sresp, a_m1_sresp); end
      end
    end
    step();
    idle_all();
    m0_cmd = OCP_CMD_RD; m0_addr = 16'h0031;
    m1_cmd = OCP_CMD_RD; m1_addr = 16'h0041;
    @(negedge clk);
    checks++; if (a_m1_acc !== 1'b1 || a_m0_acc !== 1'b0) begin errors++; $display("FAIL stall_release got m1/m0 %b%b want 10", a_m1_acc, a_m0_acc); end
  endtask

  task automatic test_reset_midflight();
    step();
    idle_all();
    m0_cmd = OCP_CMD_WR; m0_addr = 16'h0050;
    @(negedge clk);
    checks++; if (a_m0_acc !== 1'b1 || b_m0_acc !== 1'b0 + 1'b1) begin errors++; $display("FAIL mid_acc got %b/%b want 1/1", a_m0_acc, b_m0_acc); end
    step();
    idle_all();
    nrst = 1'b0;
    m0_cmd = OCP_CMD_RD;
    s_resp1 = OCP_RESP_DVA;
    @(negedge clk);
    checks++; if (a_m0_sresp !== OCP_RESP_NULL || a_m1_sresp !== OCP_RESP_NULL) begin errors++; $display("FAIL mid_rst_resp got %h/%h want 0/0", a_m0_sresp, a_m1_sresp); end
    checks++; if (a_mcmd !== OCP_CMD_IDLE || a_m0_acc !== 1'b0) begin errors++; $display("FAIL mid_rst_cmd got %h acc %b want 0 acc 0", a_mcmd, a_m0_acc); end
    step();
    idle_all();
    nrst = 1'b1;
    s_resp1 = OCP_RESP_DVA;
    s_resp2 = OCP_RESP_DVA;
    @(negedge clk);
    checks++; if (a_m0_sresp !== OCP_RESP_NULL || a_m1_sresp !== OCP_RESP_NULL) begin errors++; $display("FAIL mid_post_resp1 got %h/%h want 0/0", a_m0_sresp, a_m1_sresp); end
    checks++; if (b_m0_sresp !== OCP_RESP_NULL || b_m1_sresp !== OCP_RESP_NULL) begin errors++; $display("FAIL mid_post_resp2 got %h/%h want 0/0", b_m0_sresp, b_m1_sresp); end
    step();
    idle_all();
    m0_cmd = OCP_CMD_RD; m0_addr = 16'h0051;
    m1_cmd = OCP_CMD_RD; m1_addr = 16'h0061;
    @(negedge clk);
    checks++; if (a_m0_acc !== 1'b1 || a_m1_acc !== 1'b0) begin errors++; $display("FAIL mid_prio got m1/m0 %b%b want 01", a_m1_acc, a_m0_acc); end
  endtask

  task automatic test_lat2();
    logic exp_m1;
    logic own_m1;
    step();
    idle_all();
    for (int c = 0; c < 6; c++) begin
      step();
      idle_all();
      exp_m1 = (c % 2) == 0;
      if (c < 4) begin
        if (exp_m1) begin m1_cmd = OCP_CMD_RD; m1_addr = ADDR_WIDTH'(32'h60 + c); end
        else        begin m0_cmd = OCP_CMD_RD; m0_addr = ADDR_WIDTH'(32'h60 + c); end
      end
      if (c >= 1) begin s_resp2 = OCP_RESP_DVA; s_data = DATA_WIDTH'(32'hE0 + c); end
      @(negedge clk);
      if (c < 4) begin
        checks++; if (b_m1_acc !== exp_m1 || b_m0_acc !== !exp_m1) begin errors++; $display("FAIL lat2_acc c=%0d got m1/m0 %b%b want m1=%b", c, b_m1_acc, b_m0_acc, exp_m1); end
      end
      if (c == 1) begin
        checks++; if (b_m0_sresp !== OCP_RESP_NULL || b_m1_sresp !== OCP_RESP_NULL) begin errors++; $display("FAIL lat2_early got %h/%h want 0/0", b_m0_sresp, b_m1_sresp); end
      end
      if (c >= 2) begin
        own_m1 = ((c - 2) % 2) == 0;
        checks++;
        if (b_m1_sresp !== (own_m1 ? OCP_RESP_DVA : OCP_RESP_NULL) || b_m0_sresp !== (own_m1 ? OCP_RESP_NULL : OCP_RESP_DVA)) begin
          errors++; $display("FAIL lat2_route c=%0d got m0=%h m1=%h want owner m1=%b", c, b_m0_sresp, b_m1_sresp, own_m1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_reset_midflight();
    test_lat2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
